// File: rtl/iob_vexriscv_mem_arbiter_pkg.sv
// rtl/iob_vexriscv_mem_arbiter_pkg.sv - shared encodings for the VexRiscv memory arbiter
// Purpose: owner IDs, lock state encoding and owner FIFO depth derivation.
// Ports: none (package).
package iob_vexriscv_mem_arbiter_pkg;

  localparam logic IBUS_ID = 1'b0;
  localparam logic DBUS_ID = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int owner_fifo_depth(input int outst_w);
    return 1 << outst_w;
  endfunction

endpackage

// File: rtl/iob_vexriscv_mem_arbiter_if.sv
// rtl/iob_vexriscv_mem_arbiter_if.sv - IOb native memory port bundle
// Purpose: one IOb request/response port.
// Signals: avalid/addr/wdata/wstrb (request), rdata/rvalid/ready (response).
// Modports: master drives the request, slave drives the response.
interface iob_vexriscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  ready;

  modport master (output avalid, addr, wdata, wstrb, input rdata, rvalid, ready);
  modport slave  (input avalid, addr, wdata, wstrb, output rdata, rvalid, ready);
endinterface

// File: rtl/iob_reg_re.sv
// rtl/iob_reg_re.sv - register with async reset, clock enable, sync reset and enable
// Ports: clk_i, cke_i, arst_i (async, active-high), rst_i (sync), en_i, data_i, data_o.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        data_o <= RST_VAL;
      end else if (en_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/iob_vexriscv_owner_fifo.sv
// rtl/iob_vexriscv_owner_fifo.sv - 1-bit owner FIFO for outstanding reads
// Purpose: remembers which requester issued each outstanding read, in order.
// Ports: clk_i, cke_i, arst_i; push_i/data_i (write side); pop_i/data_o (head);
//        full_o, empty_o, count_o (OUTST_W+1 bits). Depth is 2**OUTST_W.
module iob_vexriscv_owner_fifo
  import iob_vexriscv_mem_arbiter_pkg::*;
#(
  parameter int OUTST_W = 1
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic             data_i,
  input  logic             pop_i,
  output logic             data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OUTST_W:0] count_o
);

  localparam int DEPTH = owner_fifo_depth(OUTST_W);

  logic [OUTST_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [OUTST_W:0]   count_nxt;
  logic [DEPTH-1:0]   mem;
  logic               do_push, do_pop;

  assign full_o  = (count_o == (OUTST_W+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rptr];

  // Pointers wrap naturally since depth is a power of two.
  assign wptr_nxt  = wptr + OUTST_W'(1);
  assign rptr_nxt  = rptr + OUTST_W'(1);
  assign count_nxt = count_o + (OUTST_W+1)'(do_push) - (OUTST_W+1)'(do_pop);

  iob_reg_re #(.DATA_W(OUTST_W)) wptr_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
    .en_i(do_push), .data_i(wptr_nxt), .data_o(wptr)
  );

  iob_reg_re #(.DATA_W(OUTST_W)) rptr_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
    .en_i(do_pop), .data_i(rptr_nxt), .data_o(rptr)
  );

  iob_reg_re #(.DATA_W(OUTST_W+1)) count_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
    .en_i(do_push ^ do_pop), .data_i(count_nxt), .data_o(count_o)
  );

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      iob_reg_re #(.DATA_W(1)) slot_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
        .en_i(do_push && (wptr == OUTST_W'(i))), .data_i(data_i), .data_o(mem[i])
      );
    end
  endgenerate

endmodule

// File: rtl/iob_vexriscv_mem_arbiter.sv
// rtl/iob_vexriscv_mem_arbiter.sv - shares one IOb memory port between VexRiscv ibus and dbus
// Purpose: combinational arbitration with grant lock until acceptance, in-order
//          read response routing through an owner FIFO.
// Ports: clk_i, cke_i (clock enable), arst_i (async, active-high);
//        ibus, dbus (slave modports, requesters); m (master modport, memory);
//        err_o (sticky: response arrived with no outstanding read).
// Build option: IOB_VEXRISCV_ARB_RR_EN selects round-robin instead of dbus-first priority.
module iob_vexriscv_mem_arbiter
  import iob_vexriscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OUTST_W = 1
) (
  input  logic                         clk_i,
  input  logic                         cke_i,
  input  logic                         arst_i,
  iob_vexriscv_mem_arbiter_if.slave    ibus,
  iob_vexriscv_mem_arbiter_if.slave    dbus,
  iob_vexriscv_mem_arbiter_if.master   m,
  output logic                         err_o
);

  localparam int DEPTH = owner_fifo_depth(OUTST_W);

  lock_state_t         lock_r, lock_nxt;
  logic                gnt_r, gnt_nxt, gnt, rr_pick;
  logic                sel_avalid, sel_read, blocked, accept, can_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                fifo_full, fifo_empty, fifo_head;
  logic [OUTST_W:0]    fifo_count;

`ifdef IOB_VEXRISCV_ARB_RR_EN
  logic last_r;
  assign rr_pick = ~last_r;

  iob_reg_re #(.DATA_W(1), .RST_VAL(IBUS_ID)) last_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
    .en_i(accept), .data_i(gnt), .data_o(last_r)
  );
`else
  assign rr_pick = DBUS_ID;
`endif

  // While locked the stored winner keeps the port even if the other side requests.
  always_comb begin
    gnt = IBUS_ID;
    if (lock_r == LOCKED) begin
      gnt = gnt_r;
    end else if (ibus.avalid && dbus.avalid) begin
      gnt = rr_pick;
    end else if (dbus.avalid) begin
      gnt = DBUS_ID;
    end
  end

  assign sel_avalid = (gnt == DBUS_ID) ? dbus.avalid : ibus.avalid;
  assign sel_addr   = (gnt == DBUS_ID) ? dbus.addr   : ibus.addr;
  assign sel_wdata  = (gnt == DBUS_ID) ? dbus.wdata  : ibus.wdata;
  assign sel_wstrb  = (gnt == DBUS_ID) ? dbus.wstrb  : ibus.wstrb;

  // A read with no free owner slot is held back; writes need no slot.
  assign sel_read = sel_avalid & (sel_wstrb == '0);
  assign blocked  = sel_read & fifo_full;
  assign accept   = sel_avalid & ~blocked & m.ready;
  assign can_lock = (fifo_count < (OUTST_W+1)'(DEPTH));

  assign m.avalid = sel_avalid & ~blocked;
  assign m.addr   = sel_avalid ? sel_addr  : '0;
  assign m.wdata  = sel_avalid ? sel_wdata : '0;
  assign m.wstrb  = sel_avalid ? sel_wstrb : '0;

  assign ibus.ready = accept & (gnt == IBUS_ID);
  assign dbus.ready = accept & (gnt == DBUS_ID);

  assign ibus.rdata  = m.rdata;
  assign dbus.rdata  = m.rdata;
  assign ibus.rvalid = m.rvalid & ~fifo_empty & (fifo_head == IBUS_ID);
  assign dbus.rvalid = m.rvalid & ~fifo_empty & (fifo_head == DBUS_ID);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lock_r <= UNLOCKED;
      gnt_r  <= IBUS_ID;
    end else if (cke_i) begin
      lock_r <= lock_nxt;
      gnt_r  <= gnt_nxt;
    end
  end

  // Dropping avalid while locked is a protocol violation; release rather than hang.
  always_comb begin
    lock_nxt = lock_r;
    gnt_nxt  = gnt_r;
    case (lock_r)
      UNLOCKED: begin
        if (sel_avalid && !m.ready && can_lock) begin
          lock_nxt = LOCKED;
          gnt_nxt  = gnt;
        end
      end
      LOCKED: begin
        if (accept || !sel_avalid) begin
          lock_nxt = UNLOCKED;
        end
      end
    endcase
  end

  iob_vexriscv_owner_fifo #(.OUTST_W(OUTST_W)) owner_fifo (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .push_i(accept & sel_read), .data_i(gnt),
    .pop_i(m.rvalid), .data_o(fifo_head),
    .full_o(fifo_full), .empty_o(fifo_empty), .count_o(fifo_count)
  );

  iob_reg_re #(.DATA_W(1)) err_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(1'b0),
    .en_i(m.rvalid & fifo_empty), .data_i(1'b1), .data_o(err_o)
  );

endmodule

// File: tb/tb_iob_vexriscv_mem_arbiter.sv
// tb/tb_iob_vexriscv_mem_arbiter.sv - self-checking bench for iob_vexriscv_mem_arbiter
module tb_iob_vexriscv_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int OUTST_W = 1;
  localparam int DEPTH   = 2;
`ifdef IOB_VEXRISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic cke;
  logic arst;
  logic err;

  always #5 clk = ~clk;

  iob_vexriscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ibus_if ();
  iob_vexriscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbus_if ();
  iob_vexriscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  iob_vexriscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST_W(OUTST_W)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .ibus(ibus_if), .dbus(dbus_if), .m(m_if), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [3:0]  iws;
    logic [3:0]  dws;
    logic        mrdy;
    logic        mrv;
    logic [31:0] mrd;
    logic [5:0]  exp;    // {m_avalid, ibus_ready, dbus_ready, ibus_rvalid, dbus_rvalid, err}
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt[20];
  logic [1:0] ab_gnt[3];
  logic [1:0] ab_rv[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {m_if.avalid, ibus_if.ready, dbus_if.ready, ibus_if.rvalid, dbus_if.rvalid, err};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic dv, input logic [3:0] iws,
                               input logic [3:0] dws, input logic mrdy, input logic mrv,
                               input logic [31:0] mrd, input logic [5:0] exp,
                               input logic [31:0] eaddr);
    vec_t v;
    v.iv = iv; v.dv = dv; v.iws = iws; v.dws = dws; v.mrdy = mrdy; v.mrv = mrv;
    v.mrd = mrd; v.exp = exp; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic dv, input logic [3:0] iws,
                       input logic [3:0] dws, input logic mrdy, input logic mrv,
                       input logic [31:0] mrd);
    ibus_if.avalid = iv;  ibus_if.wstrb = iws; ibus_if.addr = 32'h100; ibus_if.wdata = 32'hA0A0_0001;
    dbus_if.avalid = dv;  dbus_if.wstrb = dws; dbus_if.addr = 32'h200; dbus_if.wdata = 32'hD0D0_0002;
    m_if.ready = mrdy; m_if.rvalid = mrv; m_if.rdata = mrd;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    cke  = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("reset_outs", 64'(outs()), 64'(0));
    check("reset_m_req", 64'({m_if.addr, m_if.wstrb}), 64'(0));
    @(posedge clk); #2;
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int q[$];
    int held, last, w;
    bit merr, full, req, rd, blk, e_mav, e_acc, e_irv, e_drv;
    logic iv, dv, mrdy, mrv, c;
    logic [3:0] iws, dws;
    logic [31:0] ia, da, iwd, dwd;

    // Scenario table, one row per cycle, starting from reset.
    vt[0]  = mkv(1, 0, 4'h0, 4'h0, 1, 0, 32'h0,        6'b110000, 32'h100); // ibus read accepted
    vt[1]  = mkv(0, 0, 4'h0, 4'h0, 0, 1, 32'hDEADBEEF, 6'b000100, 32'h0);   // routed to ibus
    vt[2]  = mkv(1, 1, 4'h0, 4'hF, 0, 0, 32'h0,        6'b100000, 32'h200); // dbus write stalls
    vt[3]  = mkv(1, 1, 4'h0, 4'hF, 0, 0, 32'h0,        6'b100000, 32'h200);
    vt[4]  = mkv(1, 1, 4'h0, 4'hF, 0, 0, 32'h0,        6'b100000, 32'h200);
    vt[5]  = mkv(1, 1, 4'h0, 4'hF, 1, 0, 32'h0,        6'b101000, 32'h200); // write accepted
    vt[6]  = mkv(1, 0, 4'h0, 4'h0, 1, 0, 32'h0,        6'b110000, 32'h100); // ibus read 1
    vt[7]  = mkv(1, 0, 4'h0, 4'h0, 1, 0, 32'h0,        6'b110000, 32'h100); // ibus read 2, full
    vt[8]  = mkv(1, 0, 4'h0, 4'h0, 1, 0, 32'h0,        6'b000000, 32'h0);   // third read held
    vt[9]  = mkv(1, 1, 4'h0, 4'hF, 1, 0, 32'h0,        6'b101000, 32'h200); // write still passes
    vt[10] = mkv(1, 0, 4'h0, 4'h0, 0, 0, 32'h0,        6'b000000, 32'h0);   // no lock while full
    vt[11] = mkv(1, 0, 4'h0, 4'h0, 1, 1, 32'h11111111, 6'b000100, 32'h0);
    vt[12] = mkv(1, 0, 4'h0, 4'h0, 1, 1, 32'h22222222, 6'b110100, 32'h100); // push+pop
    vt[13] = mkv(0, 1, 4'h0, 4'h0, 1, 0, 32'h0,        6'b101000, 32'h200);
    vt[14] = mkv(0, 0, 4'h0, 4'h0, 0, 1, 32'h33333333, 6'b000100, 32'h0);
    vt[15] = mkv(0, 1, 4'h0, 4'h0, 1, 1, 32'h44444444, 6'b101010, 32'h200);
    vt[16] = mkv(0, 0, 4'h0, 4'h0, 0, 1, 32'h55555555, 6'b000010, 32'h0);
    vt[17] = mkv(0, 0, 4'h0, 4'h0, 0, 1, 32'h66666666, 6'b000000, 32'h0);   // stray response
    vt[18] = mkv(0, 0, 4'h0, 4'h0, 0, 0, 32'h0,        6'b000001, 32'h0);
    vt[19] = mkv(0, 0, 4'h0, 4'h0, 1, 0, 32'h0,        6'b000001, 32'h0);

    ab_gnt[0] = 2'b01; ab_gnt[1] = RR ? 2'b10 : 2'b01; ab_gnt[2] = 2'b01;
    ab_rv[0]  = 2'b00; ab_rv[1]  = 2'b01;              ab_rv[2]  = RR ? 2'b10 : 2'b01;

    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(vt[k].iv, vt[k].dv, vt[k].iws, vt[k].dws, vt[k].mrdy, vt[k].mrv, vt[k].mrd);
      @(negedge clk);
      check($sformatf("vec%0d_outs", k), 64'(outs()), 64'(vt[k].exp));
      if (vt[k].exp[5]) check($sformatf("vec%0d_addr", k), 64'(m_if.addr), 64'(vt[k].eaddr));
      if (vt[k].mrv) check($sformatf("vec%0d_rdata", k), {ibus_if.rdata, dbus_if.rdata}, {vt[k].mrd, vt[k].mrd});
      @(posedge clk); #1;
    end

    // Both requesters reading back-to-back.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 4'h0, 4'h0, 1'b1, k > 0, 32'hC0DE_0000 + 32'(k));
      @(negedge clk);
      check($sformatf("both_gnt%0d", k), 64'({ibus_if.ready, dbus_if.ready}), 64'(ab_gnt[k]));
      check($sformatf("both_rv%0d", k), 64'({ibus_if.rvalid, dbus_if.rvalid}), 64'(ab_rv[k]));
      @(posedge clk); #1;
    end

    // Error, lock on ibus, then asynchronous reset in the middle of the lock.
    do_reset();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("lock_start_outs", 64'(outs()), 64'(6'b100001));
    check("lock_start_addr", 64'(m_if.addr), 64'(32'h100));
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("lock_hold_addr", 64'(m_if.addr), 64'(32'h100));
    check("lock_hold_outs", 64'(outs()), 64'(6'b100001));
    #2;
    arst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    #1;
    check("arst_mid_lock_outs", 64'(outs()), 64'(0));
    @(posedge clk); #2;
    arst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("post_reset_unlocked", 64'({ibus_if.ready, dbus_if.ready}), 64'(2'b01));
    @(posedge clk); #1;

    // Randomized traffic against a transaction-level model.
    do_reset();
    held = -1; last = 0; merr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      iv   = 1'($urandom_range(0, 1));
      dv   = 1'($urandom_range(0, 1));
      iws  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      dws  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      mrdy = ($urandom_range(0, 3) != 0);
      mrv  = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
      c    = ($urandom_range(0, 9) != 0);
      ia = $urandom; da = $urandom; iwd = $urandom; dwd = $urandom;
      cke = c;
      ibus_if.avalid = iv; ibus_if.wstrb = iws; ibus_if.addr = ia; ibus_if.wdata = iwd;
      dbus_if.avalid = dv; dbus_if.wstrb = dws; dbus_if.addr = da; dbus_if.wdata = dwd;
      m_if.ready = mrdy; m_if.rvalid = mrv; m_if.rdata = $urandom;

      full = (q.size() == DEPTH);
      if (held >= 0)      w = held;
      else if (iv && dv)  w = (RR && last == 1) ? 0 : 1;
      else if (dv)        w = 1;
      else if (iv)        w = 0;
      else                w = -1;
      req   = (w == 0) ? iv : (w == 1) ? dv : 1'b0;
      rd    = (w == 0) ? (iws == 4'h0) : (dws == 4'h0);
      blk   = req && rd && full;
      e_mav = req && !blk;
      e_acc = e_mav && mrdy;
      e_irv = mrv && q.size() > 0 && q[0] == 0;
      e_drv = mrv && q.size() > 0 && q[0] == 1;

      @(negedge clk);
      check($sformatf("rnd%0d_outs", cyc), 64'(outs()),
            64'({e_mav, e_acc && w == 0, e_acc && w == 1, e_irv, e_drv, merr}));
      if (e_mav)
        check($sformatf("rnd%0d_req", cyc), {m_if.addr, m_if.wdata},
              (w == 0) ? {ia, iwd} : {da, dwd});

      if (c) begin
        if (mrv) begin
          if (q.size() > 0) void'(q.pop_front());
          else merr = 1'b1;
        end
        if (e_acc && rd) q.push_back(w);
        if (e_acc) last = w;
        if (held >= 0) begin
          if (e_acc || !req) held = -1;
        end else if (req && !mrdy && !full) begin
          held = w;
        end
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_vexriscv_mem_arbiter.md
# iob_vexriscv_mem_arbiter

- Shares one IOb native memory port between the VexRiscv wrapper's instruction bus and data bus.
- Arbitrates requests with zero-cycle pass-through.
- Holds the grant until the winning request is accepted.
- Routes read responses back to their issuer in order, using a small owner FIFO.
- Sits between the CPU wrapper and the internal SRAM or cache port in single-port SoC configurations.

## Interface

Parameters:
- ADDR_W, 32, address width of all three ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- OUTST_W, 1, log2 of the maximum number of outstanding reads; owner FIFO depth is 2**OUTST_W.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all state updates are gated by it.
- arst_i  in  1  asynchronous reset, active-high.
- ibus_avalid_i, ibus_addr_i, ibus_wdata_i, ibus_wstrb_i  in  1/ADDR_W/DATA_W/DATA_W/8  instruction requester.
- ibus_rdata_o, ibus_rvalid_o, ibus_ready_o  out  DATA_W/1/1  instruction response.
- dbus_avalid_i, dbus_addr_i, dbus_wdata_i, dbus_wstrb_i  in  1/ADDR_W/DATA_W/DATA_W/8  data requester.
- dbus_rdata_o, dbus_rvalid_o, dbus_ready_o  out  DATA_W/1/1  data response.
- m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  shared memory request.
- m_rdata_i, m_rvalid_i, m_ready_i  in  DATA_W/1/1  shared memory response.
- err_o  out  1  sticky: m_rvalid_i was seen while the owner FIFO was empty.

## Operation

Transfer rules:
- A transfer is accepted on a cycle with avalid=1 and ready=1.
- wstrb≠0 marks a write; writes produce no rvalid.
- wstrb=0 marks a read; each read produces exactly one rvalid, one or more cycles after acceptance.

Request path:
- Combinational grant selects which requester drives m_*.
- Only the granted requester sees ready=m_ready_i; the other sees ready=0.
- The non-granted requester's response signals are 0, except rdata (see response routing).
- The m_* outputs are 0 when nothing is granted.

State machine (lock_r):
- UNLOCKED: the grant is computed from the current avalids.
  - If the granted avalid=1 and m_ready_i=0, move to LOCKED and store the grant in gnt_r.
- LOCKED: the grant is forced to gnt_r regardless of the other requester.
  - Return to UNLOCKED on the cycle the locked request is accepted.
  - Also return to UNLOCKED if the locked requester drops avalid; this is illegal per protocol but must be tolerated.

Owner FIFO:
- On each accepted read, push the owner (0=ibus, 1=dbus).
- On each m_rvalid_i, pop the head and assert that owner's rvalid_o for 1 cycle.
- m_rdata_i is fanned out to both rdata_o unconditionally.
- Push and pop in the same cycle: count is unchanged and pointers both advance.
- FIFO full (count=2**OUTST_W): a read from the currently granted requester is not forwarded.
  - m_avalid_o=0 and ready_o=0.
  - Writes still pass.
  - The grant does not lock while the FIFO is full.
- m_rvalid_i with the FIFO empty: the response is dropped and err_o sets. err_o is cleared only by reset.

Reset:
- Applies asynchronously, at any point including mid-transaction.
- Clears lock_r, gnt_r, last_r, FIFO pointers, count and err_o.
- Responses still in flight are lost. The system resets memory with the CPU.

## Timing

- Arbitration and request forwarding are combinational: 0 added cycles.
- A requester can be accepted back-to-back every cycle while it keeps winning.
- Response routing is combinational from m_rvalid_i: 0 added cycles.
- Outputs at reset: all ready_o=0, all rvalid_o=0, m_avalid_o=0, err_o=0.
- rdata_o follows m_rdata_i.
- Registers change only on clk_i rising edges with cke_i=1.
- The count register is OUTST_W+1 bits wide. Pointers are OUTST_W bits and wrap modulo 2**OUTST_W.

## Configuration

IOB_VEXRISCV_ARB_RR_EN:
- Defined: round-robin arbitration. When both request while UNLOCKED, the requester not equal to last_r wins. last_r updates on each acceptance.
- Undefined: fixed priority, dbus over ibus. last_r is not implemented.

## Structure

Shared package or header holds:
- owner encodings IBUS_ID=0 and DBUS_ID=1;
- lock state encodings;
- the FIFO depth derivation from OUTST_W.

Sub-module:
- iob_vexriscv_owner_fifo: 1-bit-wide synchronous FIFO with simultaneous push/pop, full and empty outputs, and count.
- The arbiter instantiates it once.
- Flops use the existing iob_reg_re primitive.

## Test plan

1. Single ibus read at addr 0x100, m_ready_i=1, memory returns 0xDEADBEEF 1 cycle later -> ibus_rvalid_o=1 with that data; dbus_rvalid_o stays 0.
2. Both requesters issue reads in the same cycle, m_ready_i=1 -> RR_EN: grants alternate dbus, ibus, dbus; without RR_EN: dbus is granted every cycle while asserting.
3. dbus write (wstrb=0xF) with m_ready_i=0 for 3 cycles while ibus requests -> grant stays on dbus for 4 cycles; ibus is accepted on cycle 5; FIFO count=1 only after the ibus read.
4. OUTST_W=1: 2 ibus reads accepted with no rvalid, then a third read -> m_avalid_o=0 and ibus_ready_o=0 until an m_rvalid_i; a dbus write in the same window still passes.
5. Push and pop in the same cycle with count=1 -> count stays 1; response order ibus, dbus is preserved across pointer wrap.
6. m_rvalid_i with an empty FIFO -> no rvalid_o asserted and err_o=1; assert arst_i mid-lock -> all outputs return to reset values immediately.
